// File: rtl/seq_divider_8b.sv
// -----------------------------------------------------------------------------
// seq_divider_8b
//
// Sequential restoring divider: DW-bit unsigned dividend / VW-bit unsigned
// divisor, producing a DW-bit quotient and a VW-bit remainder, one quotient
// bit per clock (MSB first). A zero divisor short-circuits to a saturated
// quotient with the dbz flag raised.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   request, sampled only while idle
//   dividend   in   DW-bit numerator, captured on accepted start
//   divisor    in   VW-bit denominator, captured on accepted start
//   busy       out  high while a division is in progress
//   done       out  one-cycle pulse, results valid
//   dbz        out  divide-by-zero flag, held until next accepted start
//   quotient   out  DW-bit result, held until next accepted start
//   remainder  out  VW-bit result, held until next accepted start
// -----------------------------------------------------------------------------
module seq_divider_8b #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic          dbz,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_ZERO = 2'd2
    } state_t;

    state_t        state_r;
    logic [DW-1:0] dividend_r;
    logic [VW-1:0] divisor_r;
    logic [VW-1:0] rem_r;      // partial remainder, always < divisor_r
    logic [DW-1:0] quo_r;      // quotient bits built so far, never exported mid-op
    logic [CW-1:0] cnt_r;      // index of the dividend bit consumed this cycle

    logic [VW:0]   shift_s;
    logic [VW:0]   diff_s;
    logic          ge_s;
    logic [VW-1:0] rem_next_s;
    logic [DW-1:0] quo_next_s;

    // One restoring-division step on the current partial remainder.
    always_comb begin
        shift_s    = {rem_r, dividend_r[cnt_r]};
        diff_s     = shift_s - {1'b0, divisor_r};
        // rem_r < divisor_r keeps shift_s - divisor_r within (-2^VW, 2^VW),
        // so the top bit of the (VW+1)-bit difference is an exact borrow flag.
        ge_s       = ~diff_s[VW];
        if (ge_s) begin
            rem_next_s = diff_s[VW-1:0];
        end else begin
            rem_next_s = shift_s[VW-1:0];
        end
        quo_next_s        = quo_r;
        quo_next_s[cnt_r] = ge_s;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            dividend_r <= {DW{1'b0}};
            divisor_r  <= {VW{1'b0}};
            rem_r      <= {VW{1'b0}};
            quo_r      <= {DW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            dbz        <= 1'b0;
            quotient   <= {DW{1'b0}};
            remainder  <= {VW{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        dbz        <= 1'b0;
                        busy       <= 1'b1;
                        dividend_r <= dividend;
                        divisor_r  <= divisor;
                        rem_r      <= {VW{1'b0}};
                        quo_r      <= {DW{1'b0}};
                        cnt_r      <= CW'(DW - 1);
                        if (divisor == {VW{1'b0}}) begin
                            state_r <= ST_ZERO;
                        end else begin
                            state_r <= ST_CALC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    if (cnt_r == {CW{1'b0}}) begin
                        quotient  <= quo_next_s;
                        remainder <= rem_next_s;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r - CW'(1);
                        state_r <= ST_CALC;
                    end
                end
                ST_ZERO: begin
                    quotient  <= {DW{1'b1}};
                    remainder <= {VW{1'b0}};
                    dbz       <= 1'b1;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
